// File: rtl/remap_reduce_pipe.sv
// remap_reduce_pipe: per-lane two-step bit remap plus selectable reduction,
// carried through STAGES registered slots under a valid/ready handshake.
// Optional feature: define REMAP_REDUCE_CNT_EN to add the saturating
// completed-transfer counter on out_count.

// Per-lane remap (output-reuse step r, cross-inverting step y) and reduction.
module remap_reduce_lane #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             red
);
  logic [WIDTH-1:0] r;
  // Only the lane MSB feeds the remap; the remaining bits are intentionally dropped.
  logic unused_low;
  assign unused_low = ^x[WIDTH-2:0];

  // Step r: each bit reuses an already-computed bit of r.
  always_comb begin
    r = '0;
    r[WIDTH-1] = x[WIDTH-1];
    r[WIDTH-2] = r[WIDTH-1];
    for (int i = WIDTH-3; i >= 1; i--) r[i] = ~r[i+1];
    r[0] = r[2] & r[1];
  end

  // Step y: crosses and inverts bits of r.
  always_comb begin
    y = '0;
    y[WIDTH-1] = r[WIDTH-1];
    y[WIDTH-2] = r[1];
    for (int i = WIDTH-3; i >= 1; i--) y[i] = ~r[i+1];
    y[0] = ~r[0];
  end

  // Reduction across all bits of y, operator picked by mode.
  always_comb begin
    red = 1'b0;
    case (mode)
      2'b00:   red = &y;
      2'b01:   red = |y;
      2'b10:   red = ^y;
      default: red = ~(&y);
    endcase
  end
endmodule

module remap_reduce_pipe #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_red
`ifdef REMAP_REDUCE_CNT_EN
  ,output logic [15:0]              out_count
`endif
);
  localparam int DW = CHANNELS*WIDTH;

  logic [DW-1:0]       lane_y;
  logic [CHANNELS-1:0] lane_red;

  // Result is fully formed at acceptance; stages only transport it.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    remap_reduce_lane #(.WIDTH(WIDTH)) u_lane (
      .x    (in_data[c*WIDTH +: WIDTH]),
      .mode (in_mode),
      .y    (lane_y[c*WIDTH +: WIDTH]),
      .red  (lane_red[c])
    );
  end

  logic [STAGES-1:0]                 vld_q, vld_d;
  logic [STAGES-1:0][DW-1:0]         data_q, data_d;
  logic [STAGES-1:0][CHANNELS-1:0]   red_q, red_d;
  logic                              adv;

  // Whole chain moves together; it only stalls when the last slot is blocked.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_red   = red_q[STAGES-1];

  // Next-state of the slot chain: shift on advance, hold otherwise.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    red_d  = red_q;
    if (adv) begin
      vld_d[0]  = in_valid;
      data_d[0] = lane_y;
      red_d[0]  = lane_red;
      for (int s = 1; s < STAGES; s++) begin
        vld_d[s]  = vld_q[s-1];
        data_d[s] = data_q[s-1];
        red_d[s]  = red_q[s-1];
      end
    end
  end

  // Slot registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      red_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      red_q  <= red_d;
    end
  end

`ifdef REMAP_REDUCE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count completed output transfers, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`endif
endmodule

// File: tb/tb_remap_reduce_pipe.sv
// Self-checking bench for remap_reduce_pipe (WIDTH=4, CHANNELS=2, STAGES=2).
module tb_remap_reduce_pipe;
  localparam int W  = 4;
  localparam int C  = 2;
  localparam int S  = 2;
  localparam int DW = W*C;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    in_mode;
  logic [C-1:0]  out_red;
`ifdef REMAP_REDUCE_CNT_EN
  logic [15:0]   out_count;
`endif

  remap_reduce_pipe #(.WIDTH(W), .CHANNELS(C), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_red(out_red)
`ifdef REMAP_REDUCE_CNT_EN
    , .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [DW-1:0] d; logic [C-1:0] r; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    mode;
    logic [DW-1:0] exp_data;
    logic [C-1:0]  exp_red;
  } vec_t;

  logic          hold_pend;
  logic [DW-1:0] hold_d;
  logic [C-1:0]  hold_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Lane model written straight from the bit rules, reduction via popcount.
  function automatic void model_lane(input logic [W-1:0] x, input logic [1:0] m,
                                     output logic [W-1:0] y, output logic red);
    int r[W];
    int ones;
    r[W-1] = x[W-1];
    r[W-2] = r[W-1];
    for (int i = W-3; i >= 1; i--) r[i] = 1 - r[i+1];
    r[0] = r[2] * r[1];
    y[W-1] = r[W-1][0];
    y[W-2] = r[1][0];
    for (int i = W-3; i >= 1; i--) y[i] = (1 - r[i+1]) != 0;
    y[0] = (1 - r[0]) != 0;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(y[i]);
    case (m)
      2'b00:   red = (ones == W);
      2'b01:   red = (ones > 0);
      2'b10:   red = (ones % 2) == 1;
      default: red = (ones != W);
    endcase
  endfunction

  function automatic exp_t model(input logic [DW-1:0] d, input logic [1:0] m);
    exp_t e;
    logic [W-1:0] y;
    logic rb;
    for (int c = 0; c < C; c++) begin
      model_lane(d[c*W +: W], m, y, rb);
      e.d[c*W +: W] = y;
      e.r[c] = rb;
    end
    return e;
  endfunction

  // One clock: scoreboard and handshake checks at negedge, then step past posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      hold_pend = 1'b0;
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (hold_pend) begin
        check("stall_data", {24'd0, out_data}, {24'd0, hold_d});
        check("stall_red",  {30'd0, out_red},  {30'd0, hold_r});
      end
      hold_pend = out_valid && !out_ready;
      hold_d = out_data;
      hold_r = out_red;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_data", {24'd0, out_data}, {24'd0, e.d});
          check("sb_red",  {30'd0, out_red},  {30'd0, e.r});
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, in_mode));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < budget) begin cyc(); k++; end
    check("drain_empty", sb.size(), 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hA0, 2'b01, 8'h97, 2'b11};
    vecs[1] = '{8'h00, 2'b00, 8'h77, 2'b00};
    vecs[2] = '{8'h00, 2'b01, 8'h77, 2'b11};
    vecs[3] = '{8'h00, 2'b10, 8'h77, 2'b11};
    vecs[4] = '{8'h00, 2'b11, 8'h77, 2'b11};
    vecs[5] = '{8'hF8, 2'b10, 8'h99, 2'b00};
    vecs[6] = '{8'h3C, 2'b00, 8'h79, 2'b00};
    vecs[7] = '{8'h81, 2'b11, 8'h97, 2'b11};
    vecs[8] = '{8'h5E, 2'b10, 8'h79, 2'b10};

    hold_pend = 1'b0; hold_d = '0; hold_r = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; in_mode = '0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_out_red",   {30'd0, out_red},   32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
`ifdef REMAP_REDUCE_CNT_EN
    check("rst_count", {16'd0, out_count}, 32'd0);
`endif

    // Table vectors, one at a time, with latency check
    for (int v = 0; v < 9; v++) begin
      in_valid = 1'b1; in_data = vecs[v].data; in_mode = vecs[v].mode; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0; in_data = $urandom; in_mode = 2'($urandom);
      check("lat_not_early", {31'd0, out_valid}, 32'd0);
      cyc();
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("vec_data",  {24'd0, out_data}, {24'd0, vecs[v].exp_data});
      check("vec_red",   {30'd0, out_red},  {30'd0, vecs[v].exp_red});
      cyc();
    end
    drain(10);

    // Stall: three back-to-back, out_ready low for 4 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0F; in_mode = 2'b01; cyc();
    in_data = 8'hF0; in_mode = 2'b10; cyc();
    in_data = 8'h88; in_mode = 2'b00;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 4; k++) cyc();
    check("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    begin
      int k = 0;
      while (!in_ready && k < 10) begin cyc(); k++; end
      check("stall_accept_bound", {31'd0, in_ready}, 32'd1);
    end
    cyc();
    drain(10);

    // Bubble and mode sampling
    in_valid = 1'b1; in_data = 8'h0F; in_mode = 2'b00; cyc();
    in_valid = 1'b0; in_mode = 2'b10; cyc();
    check("bub_first_valid", {31'd0, out_valid}, 32'd1);
    check("bub_first_red",   {30'd0, out_red}, 32'b00);
    in_valid = 1'b1; in_data = 8'h0F; in_mode = 2'b10; cyc();
    in_valid = 1'b0; in_mode = 2'b00;
    check("bub_gap", {31'd0, out_valid}, 32'd0);
    cyc();
    check("bub_second_valid", {31'd0, out_valid}, 32'd1);
    check("bub_second_red",   {30'd0, out_red}, 32'b10);
    drain(10);

    // Reset mid-flight
    in_valid = 1'b1; in_data = 8'hA5; in_mode = 2'b01; cyc();
    in_data = 8'h5A; cyc();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("rst_flight_no_valid", {31'd0, out_valid}, 32'd0);
      cyc();
    end

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      in_mode   = 2'($urandom);
      cyc();
    end
    drain(20);

`ifdef REMAP_REDUCE_CNT_EN
    // Counter: five transfers, then saturation
    do_reset();
    in_valid = 1'b1; in_data = 8'h11; in_mode = 2'b00;
    for (int k = 0; k < 5; k++) cyc();
    drain(10);
    check("count_5", {16'd0, out_count}, 32'd5);
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 65535; k++) cyc();
    drain(10);
    check("count_ffff", {16'd0, out_count}, 32'h0000FFFF);
    in_valid = 1'b1; cyc();
    drain(10);
    check("count_sat", {16'd0, out_count}, 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/remap_reduce_pipe.md
# remap_reduce_pipe

- Parametrised, pipelined successor to the bit-remap / invert / reduce chain.
- Function per lane:
  - Take CHANNELS independent WIDTH-bit lanes.
  - Apply the two-step remap (output-reuse stage, then cross-inverting stage).
  - Reduce the result with a per-transaction selectable operator.
- Timing: the result is carried through STAGES registered stages under a valid/ready handshake.
- Use: corpus circuit for the netlist flow, exercising output reuse, parameter generate loops, handshake stalls and register chains together.

## Interface

Parameters:
- WIDTH, 4, bits per lane; legal range 4..32.
- CHANNELS, 2, number of lanes; legal range 1..8.
- STAGES, 2, pipeline register stages; legal range 1..8.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  CHANNELS*WIDTH  lane c occupies bits [c*WIDTH +: WIDTH].
- in_mode  input  2  reduction operator: 00 AND, 01 OR, 10 XOR, 11 NAND.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  CHANNELS*WIDTH  remapped lanes, same packing as in_data.
- out_red  output  CHANNELS  bit c is the reduction of remapped lane c.
- out_count  output  16  completed-transfer count; present only with REMAP_REDUCE_CNT_EN.

## Operation

Per-lane remap, for x = lane input and W = WIDTH. Computed combinationally at the input.
- Step r:
  - r[W-1] = x[W-1]
  - r[W-2] = r[W-1]
  - r[i] = ~r[i+1] for 1 ≤ i ≤ W-3
  - r[0] = r[2] & r[1]
- Step y:
  - y[W-1] = r[W-1]
  - y[W-2] = r[1]
  - y[i] = ~r[i+1] for 1 ≤ i ≤ W-3
  - y[0] = ~r[0]
- The reduction applies in_mode across all W bits of y; NAND = ~(&y).
- {y, reduction} for every lane is computed at acceptance and then only transported. No further logic runs on it in the stages.
- in_mode is sampled only at acceptance; a later change does not affect results in flight.

Pipeline:
- STAGES slots, each holding a valid bit and a data payload.
- Global advance: adv = ~out_valid | out_ready; in_ready = adv.
- When adv is high:
  - Every slot loads from its predecessor.
  - Slot 0 loads {in_valid, payload}.
- When adv is low, all slots hold.
- out_valid, out_data and out_red are driven directly from the last slot (registered outputs).
- Bubbles propagate: an idle input cycle while adv is high inserts an invalid slot.
- Slot payloads are don't-care while their valid bit is 0.

## Timing

- Reset: all slot valids are 0. out_valid = 0, out_data = 0, out_red = 0, in_ready = 1, out_count = 0. Payload registers also clear to 0.
- Reset mid-operation: all in-flight transactions are dropped with no output.
- Accept: in_valid & in_ready at edge N.
- Latency: out_valid rises after edge N+STAGES-1 when no stall occurs; STAGES=1 gives the result in the cycle after acceptance.
- Throughput: one transaction per cycle while out_ready stays high.
- Output stability: out_valid & ~out_ready holds out_data and out_red stable, and in_ready = 0 combinationally in that cycle.
- Simultaneous events: out_ready rising in the same cycle as in_valid allows the drain and the accept on the same edge.
- No combinational path from in_valid or in_data to any output; in_ready depends on out_ready and out_valid only.

## Configuration

- REMAP_REDUCE_CNT_EN defined:
  - out_count exists.
  - It increments by 1 on each edge where out_valid & out_ready.
  - It saturates at 16'hFFFF and clears on rst.
- REMAP_REDUCE_CNT_EN undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use WIDTH=4, CHANNELS=2, STAGES=2 unless stated.
- Basic transform:
  - Stimulus: in_data = 8'hA0, mode 01, out_ready = 1.
  - Required: out_valid exactly one cycle after the accept edge, out_data = 8'h97, out_red = 2'b11.
- All operators:
  - Stimulus: lane value 4'h0 with modes 00/01/10/11.
  - Required: y = 4'h7; out_red bit = 0, 1, 1, 1 respectively.
- Stall:
  - Stimulus: accept 3 back-to-back transactions, hold out_ready = 0 for 4 cycles, then release.
  - Required:
    - in_ready = 0 once out_valid is high.
    - out_data stable during the stall.
    - Results appear in order with no loss or duplication.
- Bubble and mode sampling:
  - Stimulus: accept with mode 00, then one idle cycle, then change in_mode to 10 on the next accept.
  - Required: first result uses AND and second uses XOR, separated by one out_valid-low cycle.
- Reset mid-flight:
  - Stimulus: assert rst for one cycle with 2 transactions in flight.
  - Required: out_valid = 0 on the next cycle; no stale result ever emerges.
- Counter (REMAP_REDUCE_CNT_EN defined, STAGES=1):
  - Stimulus: 5 completed transfers; separately force the count to 16'hFFFF via 65535 transfers, then perform one more.
  - Required: out_count = 5 after the first run, and remains 16'hFFFF at saturation.
